// File: rtl/hero_ctl_unit_pkg.sv
// Shared grid constants, direction/state encodings and cell-phase helpers for the hero controller.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package hero_ctl_unit_pkg;

    localparam int POS_W   = 12;
    localparam int PHASE_W = 6;

    // Playfield grid; map_ctl_unit works on the same cell geometry.
    localparam int GRID_X0 = 61;
    localparam int GRID_Y0 = 108;
    localparam int CELL    = 60;
    localparam int GRID_W  = 15;
    localparam int GRID_H  = 10;

    // Bit order matches key[] and collision[]; opposite directions differ only in bit 0.
    typedef enum logic [1:0] {
        DIR_LEFT  = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_UP    = 2'd3
    } dir_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_MOVING = 1'b1
    } state_t;

    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

    function automatic logic is_horiz(input dir_t d);
        return ~d[1];
    endfunction

    function automatic logic [PHASE_W-1:0] phase_inc(input logic [PHASE_W-1:0] p);
        return (p == PHASE_W'(CELL - 1)) ? '0 : p + PHASE_W'(1);
    endfunction

    function automatic logic [PHASE_W-1:0] phase_dec(input logic [PHASE_W-1:0] p);
        return (p == '0) ? PHASE_W'(CELL - 1) : p - PHASE_W'(1);
    endfunction

endpackage

// File: rtl/hero_ctl_unit_tick_gen.sv
// Free-running divider producing a one-cycle move tick every DIV clocks, with synchronous clear.
// Latency: tick is high while the counter sits at DIV-1; clr restarts the count from 0 next cycle.
// Backpressure: none; the tick is a strobe, not a handshake.
module tick_gen #(
    parameter int DIV = 130000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    // Count 0..DIV-1 and wrap; clear wins so a restart realigns the tick phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/hero_ctl_unit.sv
// Hero movement controller: held keys plus map collision vector -> pixel position, one px per tick.
// Latency: position, direction and moving are registered and change one clk after the tick cycle.
// Backpressure: none; a blocked or out-of-bounds step is simply not taken and the hero idles.
module hero_ctl_unit
    import hero_ctl_unit_pkg::*;
#(
    parameter int TICK_DIV = 130000,
    parameter int X_INIT   = 61,
    parameter int Y_INIT   = 108,
    parameter int X_MAX    = 901,
    parameter int Y_MAX    = 648
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       key,
    input  logic [3:0]       collision,
    input  logic             restart,
    output logic [POS_W-1:0] hero_x_pos,
    output logic [POS_W-1:0] hero_y_pos,
    output logic [1:0]       hero_dir,
    output logic             moving
);

    localparam logic [POS_W-1:0] X_LO  = POS_W'(GRID_X0);
    localparam logic [POS_W-1:0] Y_LO  = POS_W'(GRID_Y0);
    localparam logic [POS_W-1:0] X_HI  = POS_W'(X_MAX);
    localparam logic [POS_W-1:0] Y_HI  = POS_W'(Y_MAX);
    localparam logic [POS_W-1:0] X_RST = POS_W'(X_INIT);
    localparam logic [POS_W-1:0] Y_RST = POS_W'(Y_INIT);

    logic               tick;
    state_t             state;
    state_t             state_nxt;
    dir_t               dir_q;
    dir_t               dir_nxt;
    logic               step;
    logic [PHASE_W-1:0] phase_x;
    logic [PHASE_W-1:0] phase_y;
    logic               req_vld;
    dir_t               req;
    logic [3:0]         in_bounds;
    logic [3:0]         legal;
    logic               aligned;

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (restart),
        .tick (tick)
    );

    assign hero_dir = dir_q;
    assign moving   = (state == ST_MOVING);

    // Pick the requested direction: up beats down beats left beats right.
    always_comb begin
        req_vld = |key;
        req     = DIR_RIGHT;
        if (key[3]) begin
            req = DIR_UP;
        end else if (key[2]) begin
            req = DIR_DOWN;
        end else if (key[0]) begin
            req = DIR_LEFT;
        end else if (key[1]) begin
            req = DIR_RIGHT;
        end
    end

    // Per-direction bound check (done before stepping, so 61/108 never underflow) and legality.
    always_comb begin
        in_bounds[DIR_LEFT]  = (hero_x_pos > X_LO);
        in_bounds[DIR_RIGHT] = (hero_x_pos < X_HI);
        in_bounds[DIR_DOWN]  = (hero_y_pos < Y_HI);
        in_bounds[DIR_UP]    = (hero_y_pos > Y_LO);
        // Leaving an axis sideways is only possible on a cell boundary of the other axis.
        legal[DIR_LEFT]  = in_bounds[DIR_LEFT]  && !collision[DIR_LEFT]  && (phase_y == '0);
        legal[DIR_RIGHT] = in_bounds[DIR_RIGHT] && !collision[DIR_RIGHT] && (phase_y == '0);
        legal[DIR_DOWN]  = in_bounds[DIR_DOWN]  && !collision[DIR_DOWN]  && (phase_x == '0);
        legal[DIR_UP]    = in_bounds[DIR_UP]    && !collision[DIR_UP]    && (phase_x == '0);
        aligned = is_horiz(dir_q) ? (phase_x == '0) : (phase_y == '0);
    end

    // Movement decision, evaluated only on tick cycles; restart overrides it in the registers.
    always_comb begin
        state_nxt = state;
        dir_nxt   = dir_q;
        step      = 1'b0;
        if (tick) begin
            case (state)
                ST_IDLE: begin
                    if (req_vld && legal[req]) begin
                        dir_nxt   = req;
                        step      = 1'b1;
                        state_nxt = ST_MOVING;
                    end
                end
                ST_MOVING: begin
                    if (collision[dir_q]) begin
                        // Walls stop the hero immediately, even mid-cell.
                        state_nxt = ST_IDLE;
                    end else if (req_vld && (req == opposite(dir_q)) && legal[req]) begin
                        dir_nxt = req;
                        step    = 1'b1;
                    end else if (!aligned) begin
                        // Finish the current cell regardless of keys.
                        if (in_bounds[dir_q]) begin
                            step = 1'b1;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else if (req_vld && legal[req]) begin
                        dir_nxt = req;
                        step    = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM state and facing direction; restart idles the hero but keeps its facing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            dir_q <= DIR_RIGHT;
        end else if (restart) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
            dir_q <= dir_nxt;
        end
    end

    // Position and in-cell phase; one pixel per accepted step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hero_x_pos <= X_RST;
            hero_y_pos <= Y_RST;
            phase_x    <= '0;
            phase_y    <= '0;
        end else if (restart) begin
            hero_x_pos <= X_RST;
            hero_y_pos <= Y_RST;
            phase_x    <= '0;
            phase_y    <= '0;
        end else if (step) begin
            case (dir_nxt)
                DIR_LEFT: begin
                    hero_x_pos <= hero_x_pos - POS_W'(1);
                    phase_x    <= phase_dec(phase_x);
                end
                DIR_RIGHT: begin
                    hero_x_pos <= hero_x_pos + POS_W'(1);
                    phase_x    <= phase_inc(phase_x);
                end
                DIR_DOWN: begin
                    hero_y_pos <= hero_y_pos + POS_W'(1);
                    phase_y    <= phase_inc(phase_y);
                end
                default: begin
                    hero_y_pos <= hero_y_pos - POS_W'(1);
                    phase_y    <= phase_dec(phase_y);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hero_ctl_unit.sv
// Self-checking bench for hero_ctl_unit with a 4-cycle move tick.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; all waits are fixed cycle counts.
module tb_hero_ctl_unit;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  key;
    logic [3:0]  collision;
    logic        restart;
    logic [11:0] hero_x_pos;
    logic [11:0] hero_y_pos;
    logic [1:0]  hero_dir;
    logic        moving;

    int errors = 0;
    int checks = 0;

    // Reference model state: plain pixel coordinates, cell offsets derived arithmetically.
    int mx, my, mdir, mcnt;
    bit mmov;

    hero_ctl_unit #(
        .TICK_DIV (TD),
        .X_INIT   (61),
        .Y_INIT   (108),
        .X_MAX    (901),
        .Y_MAX    (648)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key        (key),
        .collision  (collision),
        .restart    (restart),
        .hero_x_pos (hero_x_pos),
        .hero_y_pos (hero_y_pos),
        .hero_dir   (hero_dir),
        .moving     (moving)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Every window of TD*n edges contains exactly n tick edges, whatever the counter phase.
    task automatic run_ticks(input int n);
        repeat (n * TD) @(posedge clk);
        #1;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
    endtask

    function automatic bit m_inb(input int d);
        case (d)
            0:       return mx > 61;
            1:       return mx < 901;
            2:       return my < 648;
            default: return my > 108;
        endcase
    endfunction

    function automatic bit m_legal(input int d, input logic [3:0] c);
        bit other_ok;
        other_ok = (d < 2) ? (((my - 108) % 60) == 0) : (((mx - 61) % 60) == 0);
        return !c[d] && m_inb(d) && other_ok;
    endfunction

    function automatic bit m_aligned();
        return (mdir < 2) ? (((mx - 61) % 60) == 0) : (((my - 108) % 60) == 0);
    endfunction

    task automatic m_step(input int d);
        mdir = d;
        case (d)
            0:       mx = mx - 1;
            1:       mx = mx + 1;
            2:       my = my + 1;
            default: my = my - 1;
        endcase
    endtask

    task automatic m_tick(input logic [3:0] k, input logic [3:0] c);
        int req;
        req = -1;
        if (k[3]) req = 3;
        else if (k[2]) req = 2;
        else if (k[0]) req = 0;
        else if (k[1]) req = 1;
        if (!mmov) begin
            if (req >= 0 && m_legal(req, c)) begin
                m_step(req);
                mmov = 1'b1;
            end
        end else if (c[mdir]) begin
            mmov = 1'b0;
        end else if (req >= 0 && req == (mdir ^ 1) && m_legal(req, c)) begin
            m_step(req);
        end else if (!m_aligned()) begin
            if (m_inb(mdir)) m_step(mdir);
            else mmov = 1'b0;
        end else if (req >= 0 && m_legal(req, c)) begin
            m_step(req);
        end else begin
            mmov = 1'b0;
        end
    endtask

    typedef struct {
        bit         rs;
        logic [3:0] k;
        logic [3:0] c;
        int         n;
        int         ex;
        int         ey;
        int         emov;
        int         edir;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl[NV];

    initial begin
        // Rows continue from x=121, y=108, IDLE, facing right.
        tbl[0]  = '{1'b0, 4'b0010, 4'b0000, 10, 131, 108, 1, 1};
        tbl[1]  = '{1'b0, 4'b0000, 4'b0000, 50, 181, 108, 1, 1};
        tbl[2]  = '{1'b0, 4'b0000, 4'b0000,  1, 181, 108, 0, 1};
        tbl[3]  = '{1'b1, 4'b0010, 4'b0000, 19,  80, 108, 1, 1};
        tbl[4]  = '{1'b0, 4'b0010, 4'b0010,  1,  80, 108, 0, 1};
        tbl[5]  = '{1'b0, 4'b1000, 4'b0000,  3,  80, 108, 0, 1};
        tbl[6]  = '{1'b0, 4'b0001, 4'b0000,  1,  79, 108, 1, 0};
        tbl[7]  = '{1'b0, 4'b0000, 4'b0000, 18,  61, 108, 1, 0};
        tbl[8]  = '{1'b0, 4'b0001, 4'b0000,  2,  61, 108, 0, 0};
        tbl[9]  = '{1'b0, 4'b0100, 4'b0000, 60,  61, 168, 1, 2};
        tbl[10] = '{1'b0, 4'b0000, 4'b0000,  1,  61, 168, 0, 2};
        tbl[11] = '{1'b0, 4'b1010, 4'b0000,  1,  61, 167, 1, 3};
        tbl[12] = '{1'b0, 4'b0000, 4'b0010,  5,  61, 162, 1, 3};
        tbl[13] = '{1'b0, 4'b0101, 4'b0000,  1,  61, 163, 1, 2};
        tbl[14] = '{1'b0, 4'b0000, 4'b0000,  5,  61, 168, 1, 2};
        tbl[15] = '{1'b0, 4'b0000, 4'b0000,  1,  61, 168, 0, 2};

        rst       = 1'b0;
        key       = 4'b0000;
        collision = 4'b0000;
        restart   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_x", hero_x_pos, 61);
        chk("reset_y", hero_y_pos, 108);
        chk("reset_dir", hero_dir, 1);
        chk("reset_moving", moving, 0);
        rst = 1'b1;

        // Hold right for a full cell, one pixel per tick.
        key = 4'b0010;
        for (int i = 1; i <= 60; i++) begin
            run_ticks(1);
            chk($sformatf("hold_right_x_t%0d", i), hero_x_pos, 61 + i);
            chk($sformatf("hold_right_moving_t%0d", i), moving, 1);
        end
        key = 4'b0000;
        run_ticks(1);
        chk("release_aligned_x", hero_x_pos, 121);
        chk("release_aligned_moving", moving, 0);

        for (int i = 0; i < NV; i++) begin
            if (tbl[i].rs) pulse_restart();
            key       = tbl[i].k;
            collision = tbl[i].c;
            run_ticks(tbl[i].n);
            chk($sformatf("row%0d_x", i), hero_x_pos, tbl[i].ex);
            chk($sformatf("row%0d_y", i), hero_y_pos, tbl[i].ey);
            chk($sformatf("row%0d_moving", i), moving, tbl[i].emov);
            chk($sformatf("row%0d_dir", i), hero_dir, tbl[i].edir);
        end
        key       = 4'b0000;
        collision = 4'b0000;

        // Right edge: run to x=901, then further right presses are refused.
        pulse_restart();
        key = 4'b0010;
        run_ticks(840);
        chk("edge_run_x", hero_x_pos, 901);
        chk("edge_run_moving", moving, 1);
        run_ticks(1);
        chk("edge_stop_x", hero_x_pos, 901);
        chk("edge_stop_moving", moving, 0);
        run_ticks(2);
        chk("edge_idle_x", hero_x_pos, 901);
        chk("edge_idle_moving", moving, 0);

        // Restart landing exactly on a tick cycle mid-move.
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        key     = 4'b0010;
        repeat (4 * 5 + 3) @(posedge clk);
        #1;
        chk("pre_restart_x", hero_x_pos, 66);
        chk("pre_restart_moving", moving, 1);
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        chk("restart_tick_x", hero_x_pos, 61);
        chk("restart_tick_y", hero_y_pos, 108);
        chk("restart_tick_moving", moving, 0);
        chk("restart_tick_dir", hero_dir, 1);

        // Asynchronous reset while moving down, between clock edges.
        key = 4'b0100;
        run_ticks(3);
        chk("pre_areset_y", hero_y_pos, 111);
        chk("pre_areset_dir", hero_dir, 2);
        #2;
        rst = 1'b0;
        #1;
        chk("areset_x", hero_x_pos, 61);
        chk("areset_y", hero_y_pos, 108);
        chk("areset_dir", hero_dir, 1);
        chk("areset_moving", moving, 0);
        key = 4'b0000;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Randomised run against the reference model; the first cycle restarts to sync.
        mx = 61; my = 108; mdir = 1; mmov = 1'b0; mcnt = 0;
        begin
            int base_err;
            base_err = errors;
            for (int i = 0; i < 4000; i++) begin
                logic [3:0] k, c;
                bit rs;
                if ($urandom_range(0, 23) == 0) begin
                    if ($urandom_range(0, 3) == 0) key = 4'($urandom_range(0, 15));
                    else key = 4'(1 << $urandom_range(0, 3));
                end
                for (int b = 0; b < 4; b++) collision[b] = ($urandom_range(0, 31) == 0);
                rs      = (i == 0) || ($urandom_range(0, 499) == 0);
                restart = rs;
                k       = key;
                c       = collision;
                @(posedge clk);
                if (rs) begin
                    mx = 61; my = 108; mmov = 1'b0; mcnt = 0;
                end else begin
                    bit tk;
                    tk   = (mcnt == TD - 1);
                    mcnt = (mcnt + 1) % TD;
                    if (tk) m_tick(k, c);
                end
                #1;
                chk($sformatf("rand_c%0d_x", i), hero_x_pos, mx);
                chk($sformatf("rand_c%0d_y", i), hero_y_pos, my);
                chk($sformatf("rand_c%0d_dir", i), hero_dir, mdir);
                chk($sformatf("rand_c%0d_moving", i), moving, mmov);
                if (errors - base_err > 12) break;
            end
            restart = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
